map_keeper: RTL and testbench

- Owns the 20x15 playfield tile map that the tank blocks read; it is the writer side of the tank/map interface.
- Receives tile-change requests from both tanks on `change_a` / `change_b` and applies the destruction transitions to the map.
- Drives `map` back to both tanks and to the renderer.
- Restores the initial layout tile-by-tile when a new round starts.

---
 rtl/map_pkg.sv | 61 ++++++
 rtl/map_req_fifo.sv | 71 +++++++
 rtl/map_keeper.sv | 134 +++++++++++++
 tb/tb_map_keeper.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/map_pkg.sv
// Shared tile codes, playfield geometry, initial layout and the tile destruction rule.
// Optional macro TWO_HIT_BRICK_EN: bricks crack (2->5) before breaking instead of breaking outright.
package map_pkg;

    localparam int MAP_W     = 20;
    localparam int MAP_H     = 15;
    localparam int MAP_TILES = MAP_W * MAP_H;
    localparam int IDX_W     = 9;

    typedef logic [2:0]       tile_t;
    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic {
        ST_IDLE,
        ST_RESTORE
    } state_t;

    localparam tile_t T_EMPTY   = 3'd0;
    localparam tile_t T_STEEL   = 3'd1;
    localparam tile_t T_BRICK   = 3'd2;
    localparam tile_t T_BASE_A  = 3'd3;
    localparam tile_t T_BASE_B  = 3'd4;
    localparam tile_t T_CRACKED = 3'd5;
    localparam tile_t T_BRUSH   = 3'd6;

    // Row-major, one source line per row; steel top and bottom walls, bases on row 7.
    localparam tile_t INIT_MAP [MAP_TILES] = '{
        3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1,
        3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
        3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0,
        3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2,
        3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0,
        3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
        3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
        3'd3, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd4,
        3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
        3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
        3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd0, 3'd0,
        3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd6, 3'd6, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2,
        3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd0, 3'd0, 3'd0,
        3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
        3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1
    };

    // Brick tiles in INIT_MAP above: 8 + 4 + 10 + 10 + 4 + 8.
    localparam logic [8:0] INIT_BRICKS = 9'd44;

    function automatic tile_t next_tile(input tile_t code);
        case (code)
`ifdef TWO_HIT_BRICK_EN
            T_BRICK:   return T_CRACKED;
`else
            T_BRICK:   return T_EMPTY;
`endif
            T_CRACKED: return T_EMPTY;
            T_BRUSH:   return T_EMPTY;
            default:   return code;
        endcase
    endfunction

endpackage

// File: rtl/map_req_fifo.sv
// Hit request FIFO: two push ports in one cycle (A lands ahead of B), one pop port, synchronous flush.
module map_req_fifo
    import map_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    push_a,
    input  idx_t                    din_a,
    input  logic                    push_b,
    input  idx_t                    din_b,
    input  logic                    pop,
    output idx_t                    dout,
    output logic                    empty,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    idx_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          room_1, room_2, we_0, we_1, pop_ok;
    idx_t          wdata_0;

    // Free space is judged on the occupancy before this cycle's pop.
    always_comb begin
        room_1   = count_q < CW'(DEPTH);
        room_2   = count_q < CW'(DEPTH - 1);
        pop_ok   = pop && (count_q != '0);
        we_0     = (push_a || push_b) && room_1;
        we_1     = push_a && push_b && room_2;
        wdata_0  = push_a ? din_a : din_b;
        drop     = (push_a && push_b && !room_2) || ((push_a ^ push_b) && !room_1);
        wr_ptr_d = wr_ptr_q + PW'(we_0) + PW'(we_1);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        count_d  = count_q + CW'(we_0) + CW'(we_1) - CW'(pop_ok);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we_0) mem[wr_ptr_q] <= wdata_0;
        if (we_1) mem[wr_ptr_q + PW'(1)] <= din_b;
    end

    assign dout  = mem[rd_ptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/map_keeper.sv
// Playfield map owner: queues tank hit requests, applies tile destruction, restores the layout each round.
// Build with TWO_HIT_BRICK_EN defined for bricks that crack before breaking.
module map_keeper
    import map_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        round_restart,
    input  logic [31:0] change_a,
    input  logic [31:0] change_b,
    output logic [31:0] map [MAP_TILES],
    output logic        map_ready,
    output logic        busy,
    output logic        overflow,
    output logic [8:0]  bricks_left
);

    localparam idx_t IDX_LAST = idx_t'(MAP_TILES - 1);

    state_t      state_q, state_d;
    idx_t        idx_q, idx_d;
    logic [31:0] prev_a_q, prev_b_q;
    logic        overflow_q, overflow_d;
    logic [8:0]  bricks_q, bricks_d;
    tile_t       tile_q [MAP_TILES];
    tile_t       tile_d [MAP_TILES];

    logic        valid_a, valid_b, accept, push_a, push_b, pop;
    idx_t        fifo_dout;
    logic        fifo_empty, fifo_drop;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;
    logic        wr_en;
    idx_t        wr_idx;
    tile_t       wr_tile, old_tile;

    // A request is new only on the cycle its value first appears; out-of-range indices are ignored.
    always_comb begin
        valid_a = (change_a != '0) && (change_a != prev_a_q) && (change_a < 32'(MAP_TILES));
        valid_b = (change_b != '0) && (change_b != prev_b_q) && (change_b < 32'(MAP_TILES));
        accept  = (state_q == ST_IDLE) && !round_restart;
        push_a  = accept && valid_a;
        push_b  = accept && valid_b && !(valid_a && (change_b == change_a));
        pop     = accept && !fifo_empty;
    end

    map_req_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .flush   (round_restart),
        .push_a  (push_a),
        .din_a   (change_a[IDX_W-1:0]),
        .push_b  (push_b),
        .din_b   (change_b[IDX_W-1:0]),
        .pop     (pop),
        .dout    (fifo_dout),
        .empty   (fifo_empty),
        .count   (fifo_count),
        .drop    (fifo_drop)
    );

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        overflow_d = overflow_q | fifo_drop;
        bricks_d   = bricks_q;
        old_tile   = tile_q[fifo_dout];
        wr_en      = 1'b0;
        wr_idx     = fifo_dout;
        wr_tile    = next_tile(old_tile);
        if (round_restart) begin
            state_d    = ST_RESTORE;
            idx_d      = '0;
            overflow_d = 1'b0;
        end else if (state_q == ST_RESTORE) begin
            wr_en   = 1'b1;
            wr_idx  = idx_q;
            wr_tile = INIT_MAP[idx_q];
            idx_d   = idx_q + idx_t'(1);
            if (idx_q == IDX_LAST) begin
                state_d  = ST_IDLE;
                bricks_d = INIT_BRICKS;
            end
        end else if (pop) begin
            wr_en = 1'b1;
            if ((old_tile == T_BRICK || old_tile == T_CRACKED) && wr_tile == T_EMPTY) begin
                bricks_d = bricks_q - 9'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            prev_a_q   <= '0;
            prev_b_q   <= '0;
            overflow_q <= 1'b0;
            bricks_q   <= INIT_BRICKS;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            prev_a_q   <= change_a;
            prev_b_q   <= change_b;
            overflow_q <= overflow_d;
            bricks_q   <= bricks_d;
        end
    end

    // One tile register per map cell; at most one cell is written per cycle.
    genvar gi;
    for (gi = 0; gi < MAP_TILES; gi++) begin : g_tile
        assign tile_d[gi] = (wr_en && (wr_idx == idx_t'(gi))) ? wr_tile : tile_q[gi];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                tile_q[gi] <= INIT_MAP[gi];
            end else begin
                tile_q[gi] <= tile_d[gi];
            end
        end

        assign map[gi] = {29'd0, tile_q[gi]};
    end

    assign map_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q == ST_RESTORE) || (fifo_count != '0);
    assign overflow    = overflow_q;
    assign bricks_left = bricks_q;

endmodule

// File: tb/tb_map_keeper.sv
// Scoreboard bench for map_keeper: queue-based reference model predicts tile writes and status outputs.
module tb_map_keeper;
    import map_pkg::*;

    localparam int DEPTH = 4;
`ifdef TWO_HIT_BRICK_EN
    localparam int HIT1 = 5;
`else
    localparam int HIT1 = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        round_restart = 1'b0;
    logic [31:0] change_a = '0;
    logic [31:0] change_b = '0;
    logic [31:0] map [MAP_TILES];
    logic        map_ready, busy, overflow;
    logic [8:0]  bricks_left;

    map_keeper #(.FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .round_restart (round_restart),
        .change_a      (change_a),
        .change_b      (change_b),
        .map           (map),
        .map_ready     (map_ready),
        .busy          (busy),
        .overflow      (overflow),
        .bricks_left   (bricks_left)
    );

    always #5 clk = ~clk;

    typedef struct {
        int idx;
        int val;
    } wr_t;

    int          total = 0;
    int          bad = 0;
    wr_t         exp_q[$];
    int          m_q[$];
    int          m_map [MAP_TILES];
    int          snap [MAP_TILES];
    logic [31:0] m_prev_a = '0;
    logic [31:0] m_prev_b = '0;
    int          m_bricks, m_rst_cnt, init_bricks;
    bit          m_ovf = 1'b0;
    bit          mon_on = 1'b0;
    bit          mon_skip = 1'b0;

    task automatic chk(input string name, input int act, input int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic int ref_next(input int code);
        if (code == 2) return HIT1;
        if (code == 5 || code == 6) return 0;
        return code;
    endfunction

    function automatic int map_vs_init();
        int n = 0;
        for (int i = 0; i < MAP_TILES; i++) if (int'(map[i]) != int'(INIT_MAP[i])) n++;
        return n;
    endfunction

    // Called at a negedge: check outputs against the model, drive inputs, advance the model one edge.
    task automatic step(input logic [31:0] ca, input logic [31:0] cb, input bit rr);
        int  room, idx, old_t, new_t;
        bit  new_a, new_b, restoring;
        int  cand[$];
        chk("bricks_left", int'(bricks_left), m_bricks);
        chk("overflow", int'(overflow), int'(m_ovf));
        chk("busy", int'(busy), int'(m_q.size() > 0 || m_rst_cnt > 0));
        chk("map_ready", int'(map_ready), int'(m_rst_cnt == 0));
        change_a = ca;
        change_b = cb;
        round_restart = rr;
        restoring = (m_rst_cnt > 0);
        mon_skip = restoring || rr;
        new_a = (ca != 0) && (ca != m_prev_a);
        new_b = (cb != 0) && (cb != m_prev_b);
        m_prev_a = ca;
        m_prev_b = cb;
        if (rr) begin
            m_q.delete();
            m_ovf = 1'b0;
            m_rst_cnt = MAP_TILES;
        end else if (restoring) begin
            m_rst_cnt--;
            if (m_rst_cnt == 0) begin
                for (int i = 0; i < MAP_TILES; i++) m_map[i] = int'(INIT_MAP[i]);
                m_bricks = init_bricks;
            end
        end else begin
            room = DEPTH - m_q.size();
            if (m_q.size() > 0) begin
                idx = m_q.pop_front();
                old_t = m_map[idx];
                new_t = ref_next(old_t);
                if (new_t != old_t) exp_q.push_back('{idx, new_t});
                m_map[idx] = new_t;
                if ((old_t == 2 || old_t == 5) && new_t == 0) m_bricks--;
            end
            if (new_a && ca < MAP_TILES) cand.push_back(int'(ca));
            if (new_b && cb < MAP_TILES && !(cand.size() > 0 && cand[0] == int'(cb)))
                cand.push_back(int'(cb));
            foreach (cand[k]) begin
                if (room > 0) begin
                    m_q.push_back(cand[k]);
                    room--;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(negedge clk);
    endtask

    // Monitor: every visible tile change must match the oldest predicted write.
    initial begin
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < MAP_TILES; i++) begin
                if (int'(map[i]) != snap[i]) begin
                    if (mon_on && !mon_skip) begin
                        if (exp_q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_write tile=%0d actual=%0d required=unchanged(%0d)",
                                     i, map[i], snap[i]);
                        end else begin
                            e = exp_q.pop_front();
                            chk("write_idx", i, e.idx);
                            chk("write_val", int'(map[i]), e.val);
                            $display("apply tile=%0d code=%0d", i, map[i]);
                        end
                    end
                    snap[i] = int'(map[i]);
                end
            end
            if (mon_on && !mon_skip) begin
                chk("missing_write", exp_q.size(), 0);
                exp_q.delete();
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lowcnt;
        int r;
        logic [31:0] ca, cb;
        init_bricks = 0;
        for (int i = 0; i < MAP_TILES; i++) begin
            m_map[i] = int'(INIT_MAP[i]);
            snap[i]  = int'(INIT_MAP[i]);
            if (INIT_MAP[i] == 3'd2 || INIT_MAP[i] == 3'd5) init_bricks++;
        end
        m_bricks = init_bricks;
        m_rst_cnt = 0;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        chk("rst_bricks", int'(bricks_left), init_bricks);
        chk("rst_ready", int'(map_ready), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_overflow", int'(overflow), 0);
        chk("rst_map", map_vs_init(), 0);
        mon_on = 1'b1;

        // Held request on a brick: one apply, visible one edge after capture.
        step(45, 0, 0);
        chk("lat_before", int'(map[45]), 2);
        step(45, 0, 0);
        chk("lat_after", int'(map[45]), HIT1);
        repeat (8) step(45, 0, 0);
        chk("hold_once", int'(map[45]), HIT1);

        step(0, 0, 0);
        repeat (4) step(45, 0, 0);
        chk("rehit_tile", int'(map[45]), 0);
        chk("rehit_bricks", int'(bricks_left), init_bricks - 1);

        repeat (4) step(60, 60, 0);
        chk("same_idx", int'(map[60]), HIT1);

        step(41, 42, 0);
        step(43, 44, 0);
        step(46, 47, 0);
        repeat (6) step(0, 0, 0);
        chk("burst_ovf", int'(overflow), 1);

        // Restart with three requests still queued.
        step(105, 106, 0);
        step(107, 108, 0);
        step(107, 108, 1);
        lowcnt = 0;
        for (int k = 0; k < 320; k++) begin
            if (!map_ready) lowcnt++;
            step(0, 0, 0);
        end
        chk("restore_len", lowcnt, MAP_TILES);
        chk("restore_map", map_vs_init(), 0);
        chk("restore_bricks", int'(bricks_left), init_bricks);
        chk("restore_ovf", int'(overflow), 0);

        step(0, 300, 0);
        step(0, 0, 0);
        step(0, 5, 0);
        repeat (3) step(0, 0, 0);
        chk("steel_tile", int'(map[5]), 1);
        chk("bad_idx_ovf", int'(overflow), 0);

        ca = '0;
        cb = '0;
        for (int c = 0; c < 800; c++) begin
            r = $urandom_range(0, 9);
            if (r < 3) ca = $urandom_range(0, 319);
            else if (r == 3) ca = '0;
            else if (r == 4 && $urandom_range(0, 3) == 0) ca = $urandom();
            r = $urandom_range(0, 9);
            if (r < 3) cb = $urandom_range(0, 319);
            else if (r == 3) cb = '0;
            else if (r == 4) cb = ca;
            step(ca, cb, $urandom_range(0, 399) == 0);
        end

        for (int k = 0; k < 400; k++) begin
            if (m_q.size() == 0 && m_rst_cnt == 0) break;
            step(0, 0, 0);
        end
        step(0, 0, 0);
        chk("drain", m_q.size() + m_rst_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
